// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-port memory,
// one transaction at a time, with starvation guard and access timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            if_err_q, if_err_d;
  logic            d_err_q, d_err_d;

  logic            grant_if;
  logic [DW-1:0]   sel_addr;
  logic            fin;
  logic            fin_err;
  logic            fin_load;

  // Next-state, grant selection and completion reporting
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tcnt_d      = tcnt_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    grant_if    = 1'b0;
    sel_addr    = '0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant_if    = !d_req || (if_req && (starve_q == SW'(STARVE_LIMIT)));
          sel_addr    = grant_if ? if_addr : d_addr;
          owner_d     = !grant_if;
          mem_addr_d  = sel_addr;
          mem_wdata_d = grant_if ? '0 : d_wdata;
          busy_d      = 1'b1;
          tcnt_d      = '0;
          if (grant_if || !if_req) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
          // Misaligned accesses never touch memory
          if (sel_addr[1:0] != 2'b00) begin
            state_d = S_DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d  = S_BUSY;
            mem_en_d = 1'b1;
            mem_we_d = !grant_if && d_we;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d  = S_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          fin      = 1'b1;
          fin_load = !mem_we_q;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = S_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          fin      = 1'b1;
          fin_err  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    // Route completion to the granted port; errors zero its read data
    if (fin) begin
      if (owner_d) begin
        d_done_d = 1'b1;
        d_err_d  = fin_err;
        if (fin_err) begin
          d_rdata_d = '0;
        end else if (fin_load) begin
          d_rdata_d = mem_rdata;
        end
      end else begin
        if_done_d = 1'b1;
        if_err_d  = fin_err;
        if (fin_err) begin
          if_rdata_d = '0;
        end else if (fin_load) begin
          if_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      tcnt_q      <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tcnt_q      <= tcnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a request-level model predicts grant
// order and per-port results; a memory responder and a done monitor check them.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        owner;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
  );

  // lat: BUSY cycle on which memory answers (0 = never answers)
  typedef struct {
    bit          port;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] val;
    bit          exp_err;
    int          exp_en;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } txn_t;

  txn_t        sb_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          starve = 0;
  logic [31:0] m_if   = '0;
  logic [31:0] m_d    = '0;
  int          en_total = 0;
  int          en_mark  = 0;
  int          en_run   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit port, input logic [31:0] addr, input bit we,
                              input logic [31:0] wdata, input int lat, input logic [31:0] val);
    txn_t t;
    t.port = port; t.addr = addr; t.we = we; t.wdata = wdata; t.lat = lat; t.val = val;
    t.exp_err = 1'b0; t.exp_en = 0; t.exp_if = '0; t.exp_d = '0;
    return t;
  endfunction

  function automatic int en_cycles(input txn_t t);
    logic [31:0] a;
    a = t.addr;
    if (a[1:0] != 2'b00) return 0;
    if (t.lat == 0) return TIMEOUT;
    return t.lat;
  endfunction

  function automatic txn_t rand_txn(input bit port);
    logic [31:0] a;
    txn_t t;
    a = $urandom;
    a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    t = mk(port, a, port ? 1'($urandom_range(0, 1)) : 1'b0, $urandom,
           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4), $urandom);
    return t;
  endfunction

  // Apply one transaction's effect on the per-port read data model
  function automatic txn_t resolve(input txn_t t);
    txn_t r;
    r = t;
    r.exp_en  = en_cycles(t);
    r.exp_err = (r.exp_en == 0) || (t.lat == 0);
    if (r.exp_err) begin
      if (t.port) m_d = '0; else m_if = '0;
    end else if (!t.we) begin
      if (t.port) m_d = t.val; else m_if = t.val;
    end
    r.exp_if = m_if;
    r.exp_d  = m_d;
    return r;
  endfunction

  // Grant order: data first unless fetch has waited STARVE_LIMIT data grants
  task automatic model_round(input bit f_on, input txn_t f, input txn_t dl[$]);
    bit f_pend;
    int di;
    txn_t t;
    f_pend = f_on;
    di = 0;
    while (f_pend || di < dl.size()) begin
      if (f_pend && (di >= dl.size() || starve == STARVE_LIMIT)) begin
        t = f; f_pend = 1'b0; starve = 0;
      end else begin
        t = dl[di]; di++;
        starve = f_pend ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
      end
      sb_q.push_back(resolve(t));
    end
  endtask

  task automatic drive_f(input txn_t t, input bit solo);
    int n;
    if_addr = t.addr;
    if_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 400);
    if (!if_done) begin
      fails++; checks++;
      $display("FAIL if_done_wait actual=none expected=done within 400 cycles");
    end else if (solo) begin
      chk("if_latency", 32'(n), 32'(en_cycles(t) + 2));
    end
    @(posedge clk); #1;
    if_req  = 1'b0;
    if_addr = $urandom;
  endtask

  task automatic drive_d(input txn_t dl[$], input bit solo);
    int n;
    foreach (dl[i]) begin
      d_we = dl[i].we; d_addr = dl[i].addr; d_wdata = dl[i].wdata; d_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!d_done && n < 400);
      if (!d_done) begin
        fails++; checks++;
        $display("FAIL d_done_wait actual=none expected=done within 400 cycles");
      end else if (solo) begin
        chk("d_latency", 32'(n), 32'(en_cycles(dl[i]) + 2));
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  task automatic run_round(input bit f_on, input txn_t f, input txn_t dl[$]);
    model_round(f_on, f, dl);
    @(posedge clk); #1;
    fork
      if (f_on) drive_f(f, dl.size() == 0);
      drive_d(dl, !f_on);
    join
    repeat (2) @(posedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Memory responder: answers on the scheduled BUSY cycle, random noise otherwise
  always @(negedge clk) begin
    txn_t t;
    if (mem_en) begin
      en_total++;
      en_run++;
      if (sb_q.size() == 0) begin
        fails++; checks++;
        $display("FAIL mem_en_unexpected actual=1 expected=0 at %0t", $time);
        mem_ready = 1'b0;
      end else begin
        t = sb_q[0];
        if (en_run == 1) begin
          chk("mem_addr", mem_addr, t.addr);
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end
        chk("mem_we", 32'(mem_we), 32'(t.we));
        chk("busy_in_access", 32'(busy), 32'd1);
        mem_ready = (t.lat != 0) && (en_run == t.lat);
      end
      mem_rdata = (mem_ready && !t.we) ? t.val : $urandom;
    end else begin
      en_run    = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // Completion monitor
  always begin
    txn_t t;
    @(negedge clk); #1;
    if (if_done || d_done) begin
      if (sb_q.size() == 0) begin
        fails++; checks++;
        $display("FAIL unexpected_done actual if_done=%0b d_done=%0b expected none", if_done, d_done);
      end else begin
        t = sb_q.pop_front();
        chk("if_done", 32'(if_done), 32'(!t.port));
        chk("d_done", 32'(d_done), 32'(t.port));
        chk("owner", 32'(owner), 32'(t.port));
        chk("err", 32'(t.port ? d_err : if_err), 32'(t.exp_err));
        chk("other_err", 32'(t.port ? if_err : d_err), 32'd0);
        chk("if_rdata", if_rdata, t.exp_if);
        chk("d_rdata", d_rdata, t.exp_d);
        chk("mem_en_cycles", 32'(en_total - en_mark), 32'(t.exp_en));
        en_mark = en_total;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t f;
    txn_t dl[$];
    bit   f_on;
    int   nd;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_if_err", 32'(if_err), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // Single fetch answered on first BUSY cycle
    f = mk(0, 32'h0040_0000, 0, 0, 1, 32'h2008_000A);
    dl.delete();
    run_round(1, f, dl);
    // Simultaneous requests: data first, then fetch
    f = mk(0, 32'h0040_0010, 0, 0, 2, $urandom);
    dl.delete();
    dl.push_back(mk(1, 32'h1001_0000, 0, 0, 3, 32'h1234_5678));
    run_round(1, f, dl);
    // Data streaming while fetch waits: D,D,D,D,F,D,D
    f = mk(0, 32'h0040_0020, 0, 0, 1, $urandom);
    dl.delete();
    for (int i = 0; i < 6; i++) dl.push_back(mk(1, 32'h1001_0100 + 32'(4 * i), 0, 0, 1, $urandom));
    run_round(1, f, dl);
    // Store that never completes
    dl.delete();
    dl.push_back(mk(1, 32'h1001_0004, 1, 32'hCAFE_F00D, 0, $urandom));
    run_round(0, f, dl);
    // Misaligned load
    dl.delete();
    dl.push_back(mk(1, 32'h1001_0002, 0, 0, 1, $urandom));
    run_round(0, f, dl);

    for (int r = 0; r < 60; r++) begin
      f_on = ($urandom_range(0, 3) != 0);
      nd = $urandom_range(0, 5);
      if (!f_on && nd == 0) nd = 1;
      f = rand_txn(0);
      dl.delete();
      for (int i = 0; i < nd; i++) dl.push_back(rand_txn(1));
      run_round(f_on, f, dl);
    end

    // Reset in the middle of a stalled access
    @(posedge clk); #1;
    sb_q.push_back(mk(0, 32'h0040_0004, 0, 0, 0, 0));
    if_addr = 32'h0040_0004;
    if_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    if_req = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rstbusy_mem_en", 32'(mem_en), 32'd0);
    chk("rstbusy_busy", 32'(busy), 32'd0);
    chk("rstbusy_if_done", 32'(if_done), 32'd0);
    chk("rstbusy_d_done", 32'(d_done), 32'd0);
    chk("rstbusy_if_rdata", if_rdata, 32'd0);
    #2;
    en_mark = en_total;
    m_if = '0; m_d = '0; starve = 0;
    repeat (3) @(posedge clk);
    f = mk(0, 32'h0040_0008, 0, 0, 2, 32'h8C42_0004);
    dl.delete();
    run_round(1, f, dl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
